// File: rtl/pulse_divider_multi_pkg.sv
// Shared types and constants for the multi-channel pulse divider.
// Optional quotient counters are enabled by PULSE_DIVIDER_MULTI_QUOTIENT_EN.
package pulse_divider_multi_pkg;

  localparam int WORD_WIDTH_DEF     = 8;
  localparam int QUOTIENT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_RELOAD = 2'd0,
    ST_COUNT  = 2'd1,
    ST_DONE   = 2'd2
  } ch_state_e;

  typedef logic [WORD_WIDTH_DEF-1:0]     word_t;
  typedef logic [QUOTIENT_WIDTH_DEF-1:0] quot_t;

  localparam word_t WORD_ZERO = word_t'(0);
  localparam word_t WORD_ONE  = word_t'(1);

endpackage

// File: rtl/pulse_divider_channel.sv
// One divider channel: reload/count/done FSM, remaining counter and, when
// PULSE_DIVIDER_MULTI_QUOTIENT_EN is defined, a saturating quotient counter.
module pulse_divider_channel
  import pulse_divider_multi_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      restart_i,
  input  logic                      one_shot_i,
  input  logic [WORD_WIDTH-1:0]     div_i,
  input  logic                      pulse_i,
  output logic                      pulse_o,
  output logic [WORD_WIDTH-1:0]     rem_o,
  output logic                      done_o,
  output logic [QUOTIENT_WIDTH-1:0] quot_o
);

  localparam logic [WORD_WIDTH-1:0] W_ZERO = WORD_WIDTH'(WORD_ZERO);
  localparam logic [WORD_WIDTH-1:0] W_ONE  = WORD_WIDTH'(WORD_ONE);

  ch_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0] rem_q, rem_d;
  logic                  pulse_q, pulse_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_RELOAD;
      rem_q   <= W_ZERO;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pulse_d = 1'b0;
    if (restart_i) begin
      state_d = ST_RELOAD;
      rem_d   = W_ZERO;
    end else begin
      case (state_q)
        ST_RELOAD: begin
          if (div_i == W_ZERO) begin
            rem_d = W_ZERO;
          end else if (div_i == W_ONE && pulse_i) begin
            pulse_d = 1'b1;
            rem_d   = W_ZERO;
            state_d = one_shot_i ? ST_DONE : ST_RELOAD;
          end else begin
            // A pulse arriving in the reload cycle already counts.
            rem_d   = div_i - WORD_WIDTH'(pulse_i);
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (pulse_i) begin
            if (rem_q == W_ONE) begin
              pulse_d = 1'b1;
              rem_d   = W_ZERO;
              state_d = one_shot_i ? ST_DONE : ST_RELOAD;
            end else begin
              rem_d = rem_q - W_ONE;
            end
          end
        end
        ST_DONE: rem_d = W_ZERO;
        default: begin
          state_d = ST_RELOAD;
          rem_d   = W_ZERO;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  assign pulse_o = pulse_q;
  assign rem_o   = rem_q;
  assign done_o  = done_q;

`ifdef PULSE_DIVIDER_MULTI_QUOTIENT_EN
  logic [QUOTIENT_WIDTH-1:0] quot_q;

  // Saturates rather than wraps so a long run never reports a small count.
  always_ff @(posedge clk_i) begin
    if (clr_i || restart_i) begin
      quot_q <= '0;
    end else if (pulse_d && quot_q != {QUOTIENT_WIDTH{1'b1}}) begin
      quot_q <= quot_q + QUOTIENT_WIDTH'(1);
    end
  end

  assign quot_o = quot_q;
`else
  assign quot_o = '0;
`endif

endmodule

// File: rtl/pulse_divider_multi.sv
// Multi-channel programmable pulse divider: packs/unpacks per-channel buses.
// Quotient counters exist only with PULSE_DIVIDER_MULTI_QUOTIENT_EN defined.
module pulse_divider_multi
  import pulse_divider_multi_pkg::*;
#(
  parameter int CHANNEL_COUNT  = 4,
  parameter int WORD_WIDTH     = 8,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic [CHANNEL_COUNT-1:0]            restart,
  input  logic [CHANNEL_COUNT-1:0]            one_shot,
  input  logic [CHANNEL_COUNT*WORD_WIDTH-1:0] divisor,
  input  logic [CHANNEL_COUNT-1:0]            pulses_in,
  output logic [CHANNEL_COUNT-1:0]            pulse_out,
  output logic [CHANNEL_COUNT*WORD_WIDTH-1:0] remaining,
  output logic [CHANNEL_COUNT-1:0]            done,
  output logic [CHANNEL_COUNT*QUOTIENT_WIDTH-1:0] quotient
);

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
    pulse_divider_channel #(
      .WORD_WIDTH    (WORD_WIDTH),
      .QUOTIENT_WIDTH(QUOTIENT_WIDTH)
    ) u_ch (
      .clk_i     (clock),
      .clr_i     (clear),
      .restart_i (restart[i]),
      .one_shot_i(one_shot[i]),
      .div_i     (divisor[i*WORD_WIDTH +: WORD_WIDTH]),
      .pulse_i   (pulses_in[i]),
      .pulse_o   (pulse_out[i]),
      .rem_o     (remaining[i*WORD_WIDTH +: WORD_WIDTH]),
      .done_o    (done[i]),
      .quot_o    (quotient[i*QUOTIENT_WIDTH +: QUOTIENT_WIDTH])
    );
  end

endmodule

// File: tb/tb_pulse_divider_multi.sv
// Scoreboard bench for pulse_divider_multi: a per-cycle reference model
// queues expected outputs; a monitor pops and compares after each edge.
module tb_pulse_divider_multi;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int QW = 16;

  logic              clock = 1'b0;
  logic              clear;
  logic [CH-1:0]     restart, one_shot, pulses_in;
  logic [CH*W-1:0]   divisor;
  logic [CH-1:0]     pulse_out, done;
  logic [CH*W-1:0]   remaining;
  logic [CH*QW-1:0]  quotient;

  pulse_divider_multi #(.CHANNEL_COUNT(CH), .WORD_WIDTH(W), .QUOTIENT_WIDTH(QW)) dut (
    .clock(clock), .clear(clear), .restart(restart), .one_shot(one_shot),
    .divisor(divisor), .pulses_in(pulses_in), .pulse_out(pulse_out),
    .remaining(remaining), .done(done), .quotient(quotient)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int              stamp;
    logic [CH-1:0]   p;
    logic [CH*W-1:0] rem;
    logic [CH-1:0]   dn;
    logic [CH*QW-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel either waits for a divisor, is collecting
  // pulses toward a latched target, or is halted after a one-shot.
  bit latched [CH];
  bit halted  [CH];
  int target  [CH];
  int got     [CH];
  int quot    [CH];

  task automatic model_push();
    exp_t e;
    e.stamp = cyc; e.p = '0; e.rem = '0; e.dn = '0; e.q = '0;
    for (int c = 0; c < CH; c++) begin
      if (clear) begin
        latched[c] = 0; halted[c] = 0; target[c] = 0; got[c] = 0; quot[c] = 0;
      end else if (restart[c]) begin
        latched[c] = 0; halted[c] = 0; quot[c] = 0;
      end else if (halted[c]) begin
        e.dn[c] = 1'b1;
      end else begin
        if (!latched[c]) begin
          target[c]  = int'(divisor[c*W +: W]);
          got[c]     = 0;
          latched[c] = (target[c] != 0);
        end
        if (latched[c]) begin
          got[c] += int'(pulses_in[c]);
          if (got[c] == target[c]) begin
            e.p[c] = 1'b1;
            latched[c] = 0;
            if (quot[c] < (1 << QW) - 1) quot[c]++;
            if (one_shot[c]) halted[c] = 1;
          end
        end
        e.rem[c*W +: W] = latched[c] ? W'(target[c] - got[c]) : '0;
        e.dn[c] = halted[c];
      end
`ifdef PULSE_DIVIDER_MULTI_QUOTIENT_EN
      e.q[c*QW +: QW] = QW'(quot[c]);
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  always @(posedge clock) begin
    #3;
    while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pulse_out", 64'(pulse_out), 64'(e.p));
      chk("remaining", 64'(remaining), 64'(e.rem));
      chk("done",      64'(done),      64'(e.dn));
      chk("quotient",  64'(quotient),  64'(e.q));
    end
  end

  task automatic tick();
    model_push();
    @(posedge clock);
    #1;
  endtask

  task automatic set_div(input int c, input int v);
    divisor[c*W +: W] = W'(v);
  endtask

  initial begin
    clear = 1'b1; restart = '0; one_shot = '0; pulses_in = '0; divisor = '0;
    tick();
    clear = 1'b0;

    // Held pulses, divisor 3, continuous
    set_div(0, 3);
    pulses_in[0] = 1'b1;
    repeat (9) tick();
    pulses_in[0] = 1'b0;
    repeat (3) tick();

    // Sparse pulses leave a remainder
    clear = 1'b1; tick(); clear = 1'b0;
    set_div(0, 3);
    for (int k = 0; k < 7; k++) begin
      pulses_in[0] = 1'b1; tick();
      pulses_in[0] = 1'b0; tick(); tick();
    end

    // One-shot on channel 1, then restart with a simultaneous pulse
    set_div(1, 2); one_shot[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pulses_in[1] = 1'b1; tick();
      pulses_in[1] = 1'b0; tick();
    end
    restart[1] = 1'b1; pulses_in[1] = 1'b1; tick();
    restart[1] = 1'b0;
    repeat (3) tick();
    pulses_in[1] = 1'b0; one_shot[1] = 1'b0; tick();

    // Divisor 1 on ch2, divisor 0 on ch3
    set_div(2, 1); set_div(3, 0);
    pulses_in[2] = 1'b1; pulses_in[3] = 1'b1;
    repeat (4) tick();
    pulses_in = '0;
    repeat (2) tick();

    // Restart mid-count, then clear together with restart
    clear = 1'b1; tick(); clear = 1'b0;
    set_div(0, 5);
    pulses_in[0] = 1'b1; repeat (3) tick();
    restart[0] = 1'b1; tick();
    restart[0] = 1'b0; tick();
    pulses_in[0] = 1'b0; tick();
    restart = '1; clear = 1'b1; pulses_in = '1; tick();
    restart = '0; clear = 1'b0; pulses_in = '0; tick();

    // Randomised traffic with mid-count divisor changes
    for (int c = 0; c < CH; c++) set_div(c, 2 + c);
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < CH; c++) begin
        pulses_in[c] = ($urandom_range(0, 99) < 60);
        restart[c]   = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 8) set_div(c, int'($urandom_range(0, 7)));
        if ($urandom_range(0, 99) < 5) one_shot[c] = ~one_shot[c];
      end
      clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear = 1'b0; restart = '0; pulses_in = '0;
    tick();

    repeat (3) @(posedge clock);
    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
